// File: rtl/gb_mem_pkg.sv
`default_nettype none
// ============================================================================
// gb_mem_pkg : region tags, memory-map constants and decode helpers shared by
//              the memory bus controller and its OAM DMA engine.
// Revision   : 1.0
// ============================================================================
package gb_mem_pkg;

  typedef enum logic [2:0] {
    CART,
    VRAM,
    WRAM,
    OAM,
    IO,
    HRAM,
    DMAREG,
    UNMAPPED
  } region_t;

  localparam logic [15:0] ADDR_VRAM_BASE     = 16'h8000;
  localparam logic [15:0] ADDR_CRAM_BASE     = 16'hA000;
  localparam logic [15:0] ADDR_WRAM_BASE     = 16'hC000;
  localparam logic [15:0] ADDR_ECHO_BASE     = 16'hE000;
  localparam logic [15:0] ADDR_OAM_BASE      = 16'hFE00;
  localparam logic [15:0] ADDR_UNMAPPED_BASE = 16'hFEA0;
  localparam logic [15:0] ADDR_IO_BASE       = 16'hFF00;
  localparam logic [15:0] ADDR_HRAM_BASE     = 16'hFF80;
  localparam logic [15:0] ADDR_IE            = 16'hFFFF;
  localparam logic [15:0] ADDR_DMA           = 16'hFF46;
  localparam logic [15:0] ECHO_OFFSET        = 16'h2000;

  localparam logic [7:0] DMA_ECHO_SRC_BASE   = 8'hE0;
  localparam logic [7:0] DMA_ECHO_SRC_OFFSET = 8'h20;

  localparam int SEL_CART  = 0;
  localparam int SEL_VRAM  = 1;
  localparam int SEL_WRAM  = 2;
  localparam int SEL_OAM   = 3;
  localparam int SEL_IO    = 4;
  localparam int SEL_WIDTH = 5;

  function automatic region_t decode_region(input logic [15:0] addr);
    region_t r;
    if (addr < ADDR_VRAM_BASE)                        r = CART;
    else if (addr < ADDR_CRAM_BASE)                   r = VRAM;
    else if (addr < ADDR_WRAM_BASE)                   r = CART;
    else if (addr < ADDR_OAM_BASE)                    r = WRAM;
    else if (addr < ADDR_UNMAPPED_BASE)               r = OAM;
    else if (addr < ADDR_IO_BASE)                     r = UNMAPPED;
    else if (addr == ADDR_DMA)                        r = DMAREG;
    else if (addr < ADDR_HRAM_BASE || addr == ADDR_IE) r = IO;
    else                                              r = HRAM;
    return r;
  endfunction

  // Echo RAM folds back onto WRAM so the external bus only ever sees C000-DFFF.
  function automatic logic [15:0] translate_addr(input logic [15:0] addr);
    logic [15:0] a;
    if (addr >= ADDR_ECHO_BASE && addr < ADDR_OAM_BASE) a = addr - ECHO_OFFSET;
    else                                                a = addr;
    return a;
  endfunction

  function automatic logic [SEL_WIDTH-1:0] region_sel(input region_t r);
    logic [SEL_WIDTH-1:0] sel;
    sel = '0;
    case (r)
      CART:    sel[SEL_CART] = 1'b1;
      VRAM:    sel[SEL_VRAM] = 1'b1;
      WRAM:    sel[SEL_WRAM] = 1'b1;
      OAM:     sel[SEL_OAM]  = 1'b1;
      IO:      sel[SEL_IO]   = 1'b1;
      default: sel = '0;
    endcase
    return sel;
  endfunction

  function automatic logic [7:0] region_rdata(input region_t r,
                                              input logic [7:0] cart,
                                              input logic [7:0] vram,
                                              input logic [7:0] wram,
                                              input logic [7:0] oam,
                                              input logic [7:0] io);
    logic [7:0] d;
    case (r)
      CART:    d = cart;
      VRAM:    d = vram;
      WRAM:    d = wram;
      OAM:     d = oam;
      IO:      d = io;
      default: d = 8'hFF;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_engine.sv
`default_nettype none
// ============================================================================
// oam_dma_engine : copies DMA_LENGTH bytes from {src,idx} into OAM, one byte
//                  per DMA_CLKS_PER_BYTE clocks, after a fixed start delay.
// Revision       : 1.0
// ============================================================================
module oam_dma_engine
  import gb_mem_pkg::*;
#(
  parameter int DMA_START_DELAY   = 4,
  parameter int DMA_CLKS_PER_BYTE = 4,
  parameter int DMA_LENGTH        = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  src,
  input  logic [7:0]  rdata,
  output logic        active,
  output logic        req,
  output logic        we,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  output region_t     region
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    RD    = 3'd2,
    CAP   = 3'd3,
    WR    = 3'd4,
    GAP   = 3'd5
  } state_t;

  // RD, CAP and WR take one clock each; GAP pads out the rest of the byte slot.
  localparam int         GAP_CLKS   = DMA_CLKS_PER_BYTE - 3;
  localparam logic [7:0] DELAY_LAST = 8'(DMA_START_DELAY - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CLKS - 1);
  localparam logic [7:0] IDX_LAST   = 8'(DMA_LENGTH - 1);

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] src_addr;
  logic        src_echo;
  logic        last_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    active    = (state_q != IDLE);
    req       = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wdata     = '0;
    region    = UNMAPPED;
    last_byte = (idx_q == IDX_LAST);
    // High sources fold onto WRAM, which also keeps OAM from ever being a source.
    src_echo  = (src >= DMA_ECHO_SRC_BASE);
    src_addr  = src_echo ? {src - DMA_ECHO_SRC_OFFSET, idx_q} : {src, idx_q};

    case (state_q)
      IDLE: ;
      DELAY: begin
        if (cnt_q == DELAY_LAST) state_d = RD;
        else                     cnt_d   = cnt_q + 8'd1;
      end
      RD: begin
        req     = 1'b1;
        addr    = src_addr;
        region  = src_echo ? WRAM : decode_region(src_addr);
        state_d = CAP;
      end
      CAP: begin
        data_d  = rdata;
        state_d = WR;
      end
      WR: begin
        req    = 1'b1;
        we     = 1'b1;
        addr   = ADDR_OAM_BASE + {8'h00, idx_q};
        wdata  = data_q;
        region = OAM;
        if (GAP_CLKS > 0) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (last_byte) begin
          state_d = IDLE;
        end else begin
          state_d = RD;
          idx_d   = idx_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (last_byte) begin
            state_d = IDLE;
          end else begin
            state_d = RD;
            idx_d   = idx_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = DELAY;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_bus_controller.sv
`default_nettype none
// ============================================================================
// memory_bus_controller : decodes CPU accesses onto the shared external bus,
//                         holds HRAM and arbitrates the bus with OAM DMA.
// Revision              : 1.0
// ============================================================================
module memory_bus_controller
  import gb_mem_pkg::*;
#(
  parameter int DMA_START_DELAY   = 4,
  parameter int DMA_CLKS_PER_BYTE = 4,
  parameter int DMA_LENGTH        = 160
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          cpu_addr,
  input  logic [7:0]           cpu_wdata,
  input  logic                 cpu_rw,
  output logic [7:0]           cpu_rdata,
  output logic [15:0]          bus_addr,
  output logic [7:0]           bus_wdata,
  output logic                 bus_we,
  output logic [SEL_WIDTH-1:0] bus_sel,
  input  logic [7:0]           cart_rdata,
  input  logic [7:0]           vram_rdata,
  input  logic [7:0]           wram_rdata,
  input  logic [7:0]           oam_rdata,
  input  logic [7:0]           io_rdata,
  output logic                 dma_active
);

  region_t     cpu_region;
  logic [15:0] cpu_bus_addr;
  logic        cpu_blocked;
  logic        dma_start;
  logic        hram_we;
  logic [6:0]  hram_idx;
  logic [7:0]  hram_mem [0:126];

  region_t     cpu_tag_q, cpu_tag_d;
  region_t     dma_tag_q, dma_tag_d;
  logic [7:0]  dma_reg_q, dma_reg_d;
  logic [7:0]  hram_rd_q, hram_rd_d;

  logic        eng_active;
  logic        eng_req;
  logic        eng_we;
  logic [15:0] eng_addr;
  logic [7:0]  eng_wdata;
  region_t     eng_region;
  logic [7:0]  eng_rdata;

  oam_dma_engine #(
    .DMA_START_DELAY   (DMA_START_DELAY),
    .DMA_CLKS_PER_BYTE (DMA_CLKS_PER_BYTE),
    .DMA_LENGTH        (DMA_LENGTH)
  ) u_dma (
    .clk    (clk),
    .reset  (reset),
    .start  (dma_start),
    .src    (dma_reg_q),
    .rdata  (eng_rdata),
    .active (eng_active),
    .req    (eng_req),
    .we     (eng_we),
    .addr   (eng_addr),
    .wdata  (eng_wdata),
    .region (eng_region)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_tag_q <= HRAM;
      dma_tag_q <= UNMAPPED;
      dma_reg_q <= '0;
      hram_rd_q <= '0;
    end else begin
      cpu_tag_q <= cpu_tag_d;
      dma_tag_q <= dma_tag_d;
      dma_reg_q <= dma_reg_d;
      hram_rd_q <= hram_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hram_we) hram_mem[hram_idx] <= cpu_wdata;
  end

  always_comb begin
    cpu_region   = decode_region(cpu_addr);
    cpu_bus_addr = translate_addr(cpu_addr);
    hram_idx     = cpu_addr[6:0];
    // Only HRAM and the DMA register stay reachable while the DMA owns the bus.
    cpu_blocked  = eng_active && (cpu_region != HRAM) && (cpu_region != DMAREG);
    hram_we      = cpu_rw && (cpu_region == HRAM);
    dma_start    = cpu_rw && (cpu_region == DMAREG);
    dma_reg_d    = dma_start ? cpu_wdata : dma_reg_q;
    hram_rd_d    = hram_mem[hram_idx];
    cpu_tag_d    = cpu_blocked ? UNMAPPED : cpu_region;
    dma_tag_d    = eng_region;
    eng_rdata    = region_rdata(dma_tag_q, cart_rdata, vram_rdata, wram_rdata,
                                oam_rdata, io_rdata);
  end

  always_comb begin
    case (cpu_tag_q)
      HRAM:    cpu_rdata = hram_rd_q;
      DMAREG:  cpu_rdata = dma_reg_q;
      default: cpu_rdata = region_rdata(cpu_tag_q, cart_rdata, vram_rdata,
                                        wram_rdata, oam_rdata, io_rdata);
    endcase
  end

  always_comb begin
    bus_sel   = '0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (reset) begin
      bus_sel = '0;
    end else if (eng_active) begin
      if (eng_req) begin
        bus_sel   = region_sel(eng_region);
        bus_we    = eng_we;
        bus_addr  = eng_addr;
        bus_wdata = eng_wdata;
      end
    end else if (region_sel(cpu_region) != '0) begin
      bus_sel   = region_sel(cpu_region);
      bus_we    = cpu_rw;
      bus_addr  = cpu_bus_addr;
      bus_wdata = cpu_wdata;
    end
  end

  assign dma_active = eng_active;

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_controller.sv
`default_nettype none
// ============================================================================
// tb_memory_bus_controller : scoreboard bench for decode, HRAM and OAM DMA.
// Revision                 : 1.0
// ============================================================================
module tb_memory_bus_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic [4:0]  bus_sel;
  logic [7:0]  cart_rdata, vram_rdata, wram_rdata, oam_rdata, io_rdata;
  logic        dma_active;

  logic [7:0]  wram_mem [0:8191];
  bit          preload_done = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } oam_wr_t;

  logic [7:0] rd_q [$];
  oam_wr_t    oam_q [$];

  memory_bus_controller #(
    .DMA_START_DELAY   (4),
    .DMA_CLKS_PER_BYTE (4),
    .DMA_LENGTH        (160)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rw     (cpu_rw),
    .cpu_rdata  (cpu_rdata),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_sel    (bus_sel),
    .cart_rdata (cart_rdata),
    .vram_rdata (vram_rdata),
    .wram_rdata (wram_rdata),
    .oam_rdata  (oam_rdata),
    .io_rdata   (io_rdata),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  // External memories: one-cycle synchronous read latency.
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int i = 0; i < 8192; i++) wram_mem[i] = 8'h00;
      for (int i = 0; i < 256; i++) begin
        wram_mem[16'h0100 + i] = 8'(i) ^ 8'hA5;
        wram_mem[16'h1000 + i] = 8'(i) ^ 8'h3C;
      end
      preload_done = 1'b1;
    end
    cart_rdata <= bus_addr[7:0] ^ 8'hC3;
    vram_rdata <= bus_addr[7:0] ^ 8'h79;
    wram_rdata <= wram_mem[bus_addr[12:0]];
    oam_rdata  <= bus_addr[7:0] ^ 8'h0F;
    io_rdata   <= 8'h3E;
    if (bus_we && bus_sel == 5'b00100) wram_mem[bus_addr[12:0]] = bus_wdata;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h8123; cpu_wdata = 8'hAA;
    repeat (4) cyc();
    smp();
    checks++;
    if (bus_sel !== 5'b0 || bus_addr !== 16'h0 || bus_we !== 1'b0 || bus_wdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_bus: sel=%b addr=%h we=%b wdata=%h, required all zero",
               bus_sel, bus_addr, bus_we, bus_wdata);
    end
    cyc();
    reset = 1'b0; cpu_addr = 16'hFF80;
    smp();
    checks++;
    if (cpu_rdata !== 8'h00 || dma_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdata=%h dma_active=%b, required 00/0", cpu_rdata, dma_active);
    end
    cyc();
  endtask

  task automatic test_decode_reads();
    logic [15:0] t_addr [8] = '{16'h8123, 16'h1234, 16'hA0F0, 16'hFE10,
                                16'hFF00, 16'hFFFF, 16'hFEB0, 16'hFF46};
    logic [4:0]  t_sel  [8] = '{5'b00010, 5'b00001, 5'b00001, 5'b01000,
                                5'b10000, 5'b10000, 5'b00000, 5'b00000};
    logic [15:0] t_bus  [8] = '{16'h8123, 16'h1234, 16'hA0F0, 16'hFE10,
                                16'hFF00, 16'hFFFF, 16'h0000, 16'h0000};
    logic [7:0]  t_data [8] = '{8'h5A, 8'hF7, 8'h33, 8'h1F,
                                8'h3E, 8'h3E, 8'hFF, 8'h00};
    logic [7:0]  exp;
    for (int i = 0; i <= 8; i++) begin
      cpu_rw = 1'b0;
      cpu_addr = (i < 8) ? t_addr[i] : 16'hFF80;
      smp();
      if (rd_q.size() > 0) begin
        exp = rd_q.pop_front();
        checks++;
        if (cpu_rdata !== exp) begin
          errors++;
          $display("FAIL decode_rdata[%0d]: got %h required %h", i - 1, cpu_rdata, exp);
        end
      end
      if (i < 8) begin
        checks++;
        if (bus_sel !== t_sel[i] || bus_addr !== t_bus[i] || bus_we !== 1'b0) begin
          errors++;
          $display("FAIL decode_bus[%0d]: sel=%b addr=%h we=%b required sel=%b addr=%h we=0",
                   i, bus_sel, bus_addr, bus_we, t_sel[i], t_bus[i]);
        end
        rd_q.push_back(t_data[i]);
      end
      cyc();
    end
  endtask

  task automatic test_echo_write();
    logic [7:0] exp;
    cpu_addr = 16'hE005; cpu_wdata = 8'h77; cpu_rw = 1'b1;
    smp();
    checks++;
    if (bus_sel !== 5'b00100 || bus_we !== 1'b1 || bus_addr !== 16'hC005 || bus_wdata !== 8'h77) begin
      errors++;
      $display("FAIL echo_write: sel=%b we=%b addr=%h wdata=%h required 00100/1/C005/77",
               bus_sel, bus_we, bus_addr, bus_wdata);
    end
    cyc();
    cpu_rw = 1'b0; cpu_addr = 16'hC005;
    smp();
    rd_q.push_back(8'h77);
    cyc();
    cpu_addr = 16'hFF80;
    smp();
    exp = rd_q.pop_front();
    checks++;
    if (cpu_rdata !== exp) begin
      errors++;
      $display("FAIL echo_readback: got %h required %h", cpu_rdata, exp);
    end
    cyc();
  endtask

  task automatic test_hram();
    logic [7:0] exp;
    cpu_addr = 16'hFF90; cpu_wdata = 8'h3C; cpu_rw = 1'b1;
    smp();
    checks++;
    if (bus_sel !== 5'b0 || bus_we !== 1'b0) begin
      errors++;
      $display("FAIL hram_write_bus: sel=%b we=%b required 00000/0", bus_sel, bus_we);
    end
    cyc();
    cpu_rw = 1'b0; cpu_addr = 16'hFF90;
    smp();
    checks++;
    if (bus_sel !== 5'b0) begin
      errors++;
      $display("FAIL hram_read_bus: sel=%b required 00000", bus_sel);
    end
    rd_q.push_back(8'h3C);
    cyc();
    cpu_addr = 16'hFEB0;
    smp();
    exp = rd_q.pop_front();
    checks++;
    if (cpu_rdata !== exp) begin
      errors++;
      $display("FAIL hram_read: got %h required %h", cpu_rdata, exp);
    end
    rd_q.push_back(8'hFF);
    cyc();
    cpu_addr = 16'hFF80;
    smp();
    exp = rd_q.pop_front();
    checks++;
    if (cpu_rdata !== exp) begin
      errors++;
      $display("FAIL unmapped_read: got %h required %h", cpu_rdata, exp);
    end
    cyc();
  endtask

  task automatic test_dma();
    int      active_cnt = 0;
    bit      done = 1'b0;
    bit      first_rd = 1'b0;
    oam_wr_t e;
    logic [7:0] exp;
    oam_q.delete();
    for (int i = 0; i < 160; i++) begin
      e.addr = 16'hFE00 + 16'(i);
      e.data = 8'(i) ^ 8'hA5;
      oam_q.push_back(e);
    end
    cpu_addr = 16'hFF46; cpu_wdata = 8'hC1; cpu_rw = 1'b1;
    cyc();
    cpu_rw = 1'b0; cpu_addr = 16'hFF80;
    for (int n = 0; n < 1000 && !done; n++) begin
      smp();
      if (dma_active) active_cnt++;
      else if (active_cnt > 0) done = 1'b1;
      if (!first_rd && bus_sel != 5'b0 && !bus_we) begin
        first_rd = 1'b1;
        checks++;
        if (bus_sel !== 5'b00100 || bus_addr !== 16'hC100) begin
          errors++;
          $display("FAIL dma_first_read: sel=%b addr=%h required 00100/C100", bus_sel, bus_addr);
        end
      end
      if (bus_we) begin
        checks++;
        if (oam_q.size() == 0) begin
          errors++;
          $display("FAIL dma_extra_write: addr=%h data=%h required none", bus_addr, bus_wdata);
        end else begin
          e = oam_q.pop_front();
          if (bus_sel !== 5'b01000 || bus_addr !== e.addr || bus_wdata !== e.data) begin
            errors++;
            $display("FAIL dma_oam_write: sel=%b addr=%h data=%h required 01000/%h/%h",
                     bus_sel, bus_addr, bus_wdata, e.addr, e.data);
          end
        end
      end
      cyc();
    end
    checks++;
    if (!done || active_cnt != 644) begin
      errors++;
      $display("FAIL dma_active_len: got %0d clocks (done=%0d) required 644", active_cnt, done);
    end
    checks++;
    if (oam_q.size() != 0) begin
      errors++;
      $display("FAIL dma_missing_writes: %0d outstanding required 0", oam_q.size());
    end
    cpu_addr = 16'hFF46;
    smp();
    rd_q.push_back(8'hC1);
    cyc();
    cpu_addr = 16'hFF80;
    smp();
    exp = rd_q.pop_front();
    checks++;
    if (cpu_rdata !== exp) begin
      errors++;
      $display("FAIL ff46_readback: got %h required %h", cpu_rdata, exp);
    end
    cyc();
  endtask

  task automatic test_dma_cpu_block();
    logic [7:0] exp;
    bit done = 1'b0;
    cpu_addr = 16'hFF46; cpu_wdata = 8'hC1; cpu_rw = 1'b1;
    cyc();
    cpu_rw = 1'b0; cpu_addr = 16'hFF80;
    repeat (20) cyc();
    cpu_addr = 16'hC000; cpu_wdata = 8'h11; cpu_rw = 1'b1;
    smp();
    checks++;
    if (bus_we === 1'b1 && bus_sel === 5'b00100) begin
      errors++;
      $display("FAIL block_write_bus: sel=%b we=%b addr=%h required no wram write",
               bus_sel, bus_we, bus_addr);
    end
    cyc();
    cpu_rw = 1'b0; cpu_addr = 16'h8000;
    smp();
    checks++;
    if (bus_sel === 5'b00010) begin
      errors++;
      $display("FAIL block_read_bus: sel=%b required not 00010", bus_sel);
    end
    rd_q.push_back(8'hFF);
    cyc();
    cpu_addr = 16'hFFA0; cpu_wdata = 8'h5C; cpu_rw = 1'b1;
    smp();
    exp = rd_q.pop_front();
    checks++;
    if (cpu_rdata !== exp) begin
      errors++;
      $display("FAIL block_read_data: got %h required %h", cpu_rdata, exp);
    end
    cyc();
    cpu_rw = 1'b0; cpu_addr = 16'hFFA0;
    smp();
    rd_q.push_back(8'h5C);
    cyc();
    cpu_addr = 16'hFF80;
    smp();
    exp = rd_q.pop_front();
    checks++;
    if (cpu_rdata !== exp) begin
      errors++;
      $display("FAIL hram_mid_dma: got %h required %h", cpu_rdata, exp);
    end
    cyc();
    for (int n = 0; n < 1000 && !done; n++) begin
      smp();
      if (!dma_active) done = 1'b1;
      cyc();
    end
    checks++;
    if (!done || wram_mem[0] !== 8'h00) begin
      errors++;
      $display("FAIL block_wram_untouched: done=%0d wram[C000]=%h required 1/00", done, wram_mem[0]);
    end
  endtask

  task automatic test_restart_reset();
    bit      seen50 = 1'b0;
    bit      first_rd = 1'b0;
    oam_wr_t e;
    cpu_addr = 16'hFF46; cpu_wdata = 8'hC1; cpu_rw = 1'b1;
    cyc();
    cpu_rw = 1'b0; cpu_addr = 16'hFF80;
    for (int n = 0; n < 400; n++) begin
      smp();
      if (bus_we && bus_sel == 5'b01000 && bus_addr == 16'hFE32) begin
        seen50 = 1'b1;
        break;
      end
      cyc();
    end
    checks++;
    if (!seen50) begin
      errors++;
      $display("FAIL restart_byte50: write to FE32 not seen, required seen");
    end
    cyc();
    cpu_addr = 16'hFF46; cpu_wdata = 8'hD0; cpu_rw = 1'b1;
    oam_q.delete();
    for (int i = 0; i < 10; i++) begin
      e.addr = 16'hFE00 + 16'(i);
      e.data = 8'(i) ^ 8'h3C;
      oam_q.push_back(e);
    end
    cyc();
    cpu_rw = 1'b0; cpu_addr = 16'hFF80;
    for (int n = 0; n < 200; n++) begin
      smp();
      if (!first_rd && bus_sel != 5'b0 && !bus_we) begin
        first_rd = 1'b1;
        checks++;
        if (bus_sel !== 5'b00100 || bus_addr !== 16'hD000) begin
          errors++;
          $display("FAIL restart_first_read: sel=%b addr=%h required 00100/D000", bus_sel, bus_addr);
        end
      end
      if (bus_we) begin
        checks++;
        e = oam_q.pop_front();
        if (bus_sel !== 5'b01000 || bus_addr !== e.addr || bus_wdata !== e.data) begin
          errors++;
          $display("FAIL restart_oam_write: sel=%b addr=%h data=%h required 01000/%h/%h",
                   bus_sel, bus_addr, bus_wdata, e.addr, e.data);
        end
        if (oam_q.size() == 0) break;
      end
      cyc();
    end
    checks++;
    if (oam_q.size() != 0) begin
      errors++;
      $display("FAIL restart_timeout: %0d writes outstanding required 0", oam_q.size());
    end
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    smp();
    checks++;
    if (dma_active !== 1'b0 || bus_sel !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_dma: dma_active=%b sel=%b required 0/00000", dma_active, bus_sel);
    end
    cyc();
    for (int n = 0; n < 20; n++) begin
      smp();
      checks++;
      if (bus_sel !== 5'b0 || bus_we !== 1'b0 || dma_active !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet[%0d]: sel=%b we=%b active=%b required 00000/0/0",
                 n, bus_sel, bus_we, dma_active);
      end
      cyc();
    end
  endtask

  initial begin
    reset = 1'b1; cpu_addr = 16'hFF80; cpu_wdata = 8'h00; cpu_rw = 1'b0;
    test_reset();
    test_decode_reads();
    test_echo_write();
    test_hram();
    test_dma();
    test_dma_cpu_block();
    test_restart_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_bus_controller.md
Name: memory_bus_controller

Overview:
Sits directly downstream of the CPU bus (cpu_addr/cpu_wdata/cpu_rw in, cpu_rdata out). Decodes every CPU access onto one shared external bus with one-hot region selects: cart, VRAM, WRAM, OAM, IO. Holds the 127-byte HRAM internally. Owns the OAM DMA engine triggered by writes to 0xFF46; DMA takes over the external bus while running.

Parameters:
DMA_START_DELAY, 4, clocks from the FF46 write to the first DMA read cycle
DMA_CLKS_PER_BYTE, 4, clocks per transferred byte; legal range 3..15
DMA_LENGTH, 160, bytes per DMA transfer

Ports:
clk  in  1  system clock (4 MHz)
reset  in  1  synchronous, active-high
cpu_addr  in  16  CPU address, valid every cycle
cpu_wdata  in  8  CPU write data
cpu_rw  in  1  0 = read, 1 = write; a write is performed in every cycle it is high
cpu_rdata  out  8  read data; registered, 1-cycle latency
bus_addr  out  16  external address, echo-translated
bus_wdata  out  8  external write data
bus_we  out  1  external write strobe, valid with bus_sel
bus_sel  out  5  one-hot select: bit0 cart, bit1 vram, bit2 wram, bit3 oam, bit4 io
cart_rdata  in  8  cart read data, 1-cycle synchronous latency
vram_rdata  in  8  VRAM read data, same latency
wram_rdata  in  8  WRAM read data, same latency
oam_rdata  in  8  OAM read data, same latency
io_rdata  in  8  IO register read data, same latency
dma_active  out  1  high from the FF46 write until the last OAM write completes

Behaviour:
- Reset: cpu_rdata=0x00, bus_addr=0, bus_wdata=0, bus_we=0, bus_sel=0, dma_active=0, FF46 register=0x00, DMA FSM=IDLE. HRAM contents are not reset.
- Decode is combinational onto the bus_* outputs in the same cycle:
  - 0000-7FFF and A000-BFFF: cart.
  - 8000-9FFF: vram.
  - C000-DFFF: wram.
  - E000-FDFF: wram, with bus_addr = cpu_addr - 0x2000.
  - FE00-FE9F: oam.
  - FEA0-FEFF: unmapped.
  - FF00-FF7F and FFFF: io.
  - FF80-FFFE: internal HRAM.
  - FF46: internal DMA register; not forwarded to io.
- Internal and unmapped accesses drive bus_sel=0 and bus_we=0.
- Read path: the region tag is registered in cycle N; cpu_rdata in cycle N+1 is the selected region's rdata.
  - HRAM and FF46 reads are also registered and valid at N+1.
  - Unmapped reads return 0xFF.
- Write to FF46:
  - Stores the value.
  - Sets dma_active the next cycle.
  - FSM goes IDLE -> DELAY.
  - A write to FF46 while DMA is running restarts DELAY with the new source and resets the byte index to 0.
- DMA FSM, states IDLE, DELAY, RD, CAP, WR, GAP:
  - DELAY: waits DMA_START_DELAY clocks.
  - RD: drives source address {src,idx}.
  - CAP: latches source rdata.
  - WR: drives oam, bus_we=1, bus_addr=0xFE00+idx.
  - GAP: pads the byte to DMA_CLKS_PER_BYTE clocks.
  - After idx=DMA_LENGTH-1 WR/GAP, returns to IDLE and dma_active drops.
  - Total duration = DMA_START_DELAY + DMA_LENGTH*DMA_CLKS_PER_BYTE clocks.
- DMA source decode:
  - Source high byte 0x00-0xDF uses normal decode.
  - 0xE0-0xFF maps to WRAM at (src-0x20)00.
  - An OAM-region source never selects oam for the read.
- CPU access while dma_active:
  - HRAM and FF46 behave normally.
  - All other reads return 0xFF and writes are dropped.
  - The DMA owns bus_*.
- reset mid-DMA: immediate return to IDLE, dma_active=0 on the next cycle, no further bus activity.

Decomposition:
- Package gb_mem_pkg holds:
  - region enum (CART, VRAM, WRAM, OAM, IO, HRAM, DMAREG, UNMAPPED);
  - address range constants;
  - ADDR_DMA=16'hFF46;
  - bus_sel bit indices.
- One sub-module, oam_dma_engine, contains the FSM, byte index and latched source byte. It exposes its bus request, address, write data and active flag. The top-level muxes between the CPU and this engine.

Test Plan:
- Read 0x8123 with vram_rdata=0x5A -> bus_sel=00010 and bus_addr=0x8123 same cycle; cpu_rdata=0x5A next cycle.
- Write 0xE005 with data 0x77 -> bus_sel=00100, bus_we=1, bus_addr=0xC005, bus_wdata=0x77.
- Write 0x3C to 0xFF90, then read 0xFF90 -> bus_sel=0 for both; cpu_rdata=0x3C. Read 0xFEB0 -> cpu_rdata=0xFF.
- Write 0xC1 to FF46 with a WRAM model preloaded i^0xA5 at C100+i -> 160 OAM writes FE00+i with data i^0xA5. dma_active high for exactly 644 clocks. Read FF46 afterwards -> 0xC1.
- During DMA, CPU writes 0x11 to 0xC000 and reads 0x8000 -> no CPU bus write occurs; read returns 0xFF. HRAM read/write mid-DMA works.
- Restart FF46=0xD0 at byte 50, then assert reset mid-DMA -> restart copies from D000 beginning at FE00; reset clears dma_active next cycle with bus_sel=0 thereafter.
